multi_cycle_controller: RTL and testbench
=========================================

# multi_cycle_controller

Main control FSM of the multi-cycle accumulator processor. It sits directly upstream of the ALU controller. Each cycle it drives the 3-bit `aluOp` that the ALU controller decodes, together with every datapath strobe and mux select. It consumes the ALU controller's `noOp`/`moveTo` flags and the ALU `zero` flag, sequencing fetch → decode → execute → write-back for a 16-bit instruction word.

## Interface
Parameters:
- `OPC_W`, 4: opcode width, instruction bits [15:12].

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `opcode`  in  4  IR[15:12], valid from DECODE onward.
- `zero`  in  1  ALU zero flag, used for branches.
- `noOp`  in  1  from ALU controller: suppress register write.
- `moveTo`  in  1  from ALU controller: write destination is Ri instead of R0.
- `pcWrite`  out  1  unconditional PC load.
- `pcWriteCond`  out  1  PC load qualified by `zero`.
- `pcSrc`  out  1  0 = ALU result, 1 = IR[11:0] (zero-extended).
- `iOrD`  out  1  memory address: 0 = PC, 1 = IR[11:0].
- `memRead`  out  1  memory read strobe.
- `memWrite`  out  1  memory write strobe.
- `irWrite`  out  1  instruction register load.
- `regWrite`  out  1  register file write.
- `regDst`  out  1  write address: 0 = R0, 1 = Ri (IR[11:9]).
- `memToReg`  out  1  write data: 0 = ALU result, 1 = MDR.
- `aluSrcA`  out  1  0 = PC, 1 = A (R0).
- `aluSrcB`  out  2  00 = B (Ri), 01 = constant 1, 10 = sign-extended IR[11:0].
- `aluOp`  out  3  000 add, 001 sub, 010 and, 011 or, 100 func-decode.

## Operation
- Opcodes: LOAD 0000, STORE 0001, JUMP 0010, BRANCHZ 0100, CTYPE 1000, ADDI 1100, SUBI 1101, ANDI 1110, ORI 1111. Any other opcode is treated as a NOP and returns to FETCH.
- States (4-bit encoding): FETCH 0, DECODE 1, LD_MEM 2, LD_WB 3, ST_MEM 4, JMP 5, BRZ 6, C_EXE 7, C_WB 8, I_EXE 9, I_WB 10. Codes 11–15 go to FETCH.
- Outputs are Moore (decoded from state only), with two exceptions in C_WB: `regWrite` and `regDst`, which also depend on `noOp`/`moveTo`. Any output not listed for a state is 0.
- FETCH: `iOrD`=0, `memRead`, `irWrite`, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=000, `pcSrc`=0, `pcWrite`.
  - Next state: DECODE.
- DECODE: no strobes; the datapath latches A/B. Next state by opcode:
  - LOAD → LD_MEM, STORE → ST_MEM, JUMP → JMP, BRANCHZ → BRZ.
  - CTYPE → C_EXE, ADDI/SUBI/ANDI/ORI → I_EXE.
  - Other → FETCH.
- LD_MEM: `iOrD`=1, `memRead` → LD_WB.
- LD_WB: `regWrite`, `regDst`=0, `memToReg`=1 → FETCH.
- ST_MEM: `iOrD`=1, `memWrite` → FETCH.
- JMP: `pcSrc`=1, `pcWrite` → FETCH.
- BRZ: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=001, `pcSrc`=1, `pcWriteCond` → FETCH. The PC loads only if `zero`=1.
- C_EXE: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=100 → C_WB.
- C_WB: `aluOp` held at 100, `memToReg`=0, `regWrite` = ~`noOp`, `regDst` = `moveTo` → FETCH.
- I_EXE: `aluSrcA`=1, `aluSrcB`=10, `aluOp` = {1'b0, opcode[1:0]} → I_WB.
- I_WB: same ALU selects as I_EXE, `regWrite`, `regDst`=0, `memToReg`=0 → FETCH.

## Timing
- Reset: when `rst`=0 at a rising edge, the state becomes FETCH on that edge, regardless of the current state (mid-instruction reset aborts the instruction). While `rst` is held low, all outputs equal the FETCH decode. The first fetch occurs on the first edge with `rst`=1.
- CPI:
  - JUMP, STORE, BRANCHZ: 3.
  - LOAD, CTYPE, I-type: 4.
  - Unknown opcode: 2.
- `opcode` is sampled only in DECODE. It may change in FETCH without effect.
- `noOp`/`moveTo` are sampled combinationally in C_WB only, and must be stable by the end of that cycle.
- `memRead` and `memWrite` are never both 1. `pcWrite` and `pcWriteCond` are never both 1.

## Structure
- Shared include `controller_defs.vh` holds:
  - opcode localparams,
  - state localparams,
  - `aluOp` codes (000–100, also used by the ALU controller),
  - `aluSrcB` and `pcSrc` select encodings.
- Single module: a state register plus next-state and output `always` blocks. No sub-module is warranted.

## Test plan
- `rst`=0 for 2 cycles in state C_EXE → state FETCH; `memRead`=1, `irWrite`=1, `pcWrite`=1, `aluSrcB`=01, `regWrite`=0.
- `opcode`=0000 → FETCH, DECODE, LD_MEM (`iOrD`=1, `memRead`=1), LD_WB (`regWrite`=1, `memToReg`=1, `regDst`=0), then FETCH on cycle 5.
- `opcode`=0100: with `zero`=1 in BRZ, `pcWriteCond`=1, `pcSrc`=1, `aluOp`=001; with `zero`=0, same outputs, and FETCH follows 3 cycles after the previous FETCH.
- `opcode`=1000 with `noOp`=1 in C_WB → `regWrite`=0; with `moveTo`=1, `noOp`=0 → `regWrite`=1, `regDst`=1.
- `opcode`=1110 → I_EXE with `aluOp`=010 and `aluSrcB`=10, then I_WB with `regWrite`=1.
- `opcode`=0111 → DECODE returns to FETCH next cycle; no strobe asserted in DECODE.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle accumulator controller: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package multi_cycle_controller_pkg;

  localparam int OPC_W = 4;

  // Instruction opcodes (IR[15:12])
  localparam logic [OPC_W-1:0] OP_LOAD    = 4'b0000;
  localparam logic [OPC_W-1:0] OP_STORE   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_JUMP    = 4'b0010;
  localparam logic [OPC_W-1:0] OP_BRANCHZ = 4'b0100;
  localparam logic [OPC_W-1:0] OP_CTYPE   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_ADDI    = 4'b1100;
  localparam logic [OPC_W-1:0] OP_SUBI    = 4'b1101;
  localparam logic [OPC_W-1:0] OP_ANDI    = 4'b1110;
  localparam logic [OPC_W-1:0] OP_ORI     = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_LD_MEM = 4'd2,
    S_LD_WB  = 4'd3,
    S_ST_MEM = 4'd4,
    S_JMP    = 4'd5,
    S_BRZ    = 4'd6,
    S_C_EXE  = 4'd7,
    S_C_WB   = 4'd8,
    S_I_EXE  = 4'd9,
    S_I_WB   = 4'd10
  } state_e;

  // ALU operation codes, shared with the ALU controller
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_FUNC = 3'b100;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic PCSRC_ALU = 1'b0;
  localparam logic PCSRC_IR  = 1'b1;

  localparam logic IORD_PC = 1'b0;
  localparam logic IORD_IR = 1'b1;

  // The low two opcode bits of an I-type instruction select add/sub/and/or directly.
  function automatic logic [2:0] immAluOp(input logic [OPC_W-1:0] opc);
    return {1'b0, opc[1:0]};
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control bus between the main FSM (master) and the datapath/ALU controller (slave).
interface multi_cycle_controller_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             noOp;
  logic             moveTo;

  logic             pcWrite;
  logic             pcWriteCond;
  logic             pcSrc;
  logic             iOrD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             regWrite;
  logic             regDst;
  logic             memToReg;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [2:0]       aluOp;

  modport master (
    input  opcode, zero, noOp, moveTo,
    output pcWrite, pcWriteCond, pcSrc, iOrD, memRead, memWrite, irWrite,
           regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp
  );

  modport slave (
    output opcode, zero, noOp, moveTo,
    input  pcWrite, pcWriteCond, pcSrc, iOrD, memRead, memWrite, irWrite,
           regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Main control FSM: fetch/decode/execute/write-back sequencing with Moore-decoded
// datapath strobes; only C_WB looks at the ALU controller's noOp/moveTo flags.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int OPC_W = multi_cycle_controller_pkg::OPC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_cycle_controller_if.master bus
);

  state_e           stateReg;
  state_e           stateNext;
  state_e           decState;
  logic [OPC_W-1:0] opc;

  assign opc = bus.opcode;

  // Holding reset forces the FETCH decode immediately, not just after the next edge.
  assign decState = rst ? stateReg : S_FETCH;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg <= S_FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = S_FETCH;
    unique case (stateReg)
      S_FETCH:  stateNext = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LOAD:    stateNext = S_LD_MEM;
          OP_STORE:   stateNext = S_ST_MEM;
          OP_JUMP:    stateNext = S_JMP;
          OP_BRANCHZ: stateNext = S_BRZ;
          OP_CTYPE:   stateNext = S_C_EXE;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: stateNext = S_I_EXE;
          default:    stateNext = S_FETCH;
        endcase
      end
      S_LD_MEM: stateNext = S_LD_WB;
      S_C_EXE:  stateNext = S_C_WB;
      S_I_EXE:  stateNext = S_I_WB;
      default:  stateNext = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSrc       = PCSRC_ALU;
    bus.iOrD        = IORD_PC;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = SRCB_REG;
    bus.aluOp       = ALU_ADD;
    case (decState)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.irWrite = 1'b1;
        bus.aluSrcB = SRCB_ONE;
        bus.aluOp   = ALU_ADD;
        bus.pcWrite = 1'b1;
      end
      S_LD_MEM: begin
        bus.iOrD    = IORD_IR;
        bus.memRead = 1'b1;
      end
      S_LD_WB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      S_ST_MEM: begin
        bus.iOrD     = IORD_IR;
        bus.memWrite = 1'b1;
      end
      S_JMP: begin
        bus.pcSrc   = PCSRC_IR;
        bus.pcWrite = 1'b1;
      end
      S_BRZ: begin
        // The datapath qualifies this load with the ALU zero flag.
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = ALU_SUB;
        bus.pcSrc       = PCSRC_IR;
        bus.pcWriteCond = 1'b1;
      end
      S_C_EXE: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = ALU_FUNC;
      end
      S_C_WB: begin
        bus.aluOp    = ALU_FUNC;
        bus.regWrite = ~bus.noOp;
        bus.regDst   = bus.moveTo;
      end
      S_I_EXE: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        bus.aluOp   = immAluOp(opc);
      end
      S_I_WB: begin
        bus.aluSrcA  = 1'b1;
        bus.aluSrcB  = SRCB_IMM;
        bus.aluOp    = immAluOp(opc);
        bus.regWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors are queued per instruction and
// compared against the controller outputs on each falling edge.
module tb_multi_cycle_controller;

  logic clk;
  logic rst;

  multi_cycle_controller_if #(.OPC_W(4)) bus ();

  multi_cycle_controller #(.OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcWrite,pcWriteCond,pcSrc,iOrD,memRead,memWrite,irWrite,regWrite,regDst,memToReg,aluSrcA,aluSrcB,aluOp}
  logic [15:0] outVec;
  assign outVec = {bus.pcWrite, bus.pcWriteCond, bus.pcSrc, bus.iOrD, bus.memRead,
                   bus.memWrite, bus.irWrite, bus.regWrite, bus.regDst, bus.memToReg,
                   bus.aluSrcA, bus.aluSrcB, bus.aluOp};

  int numCompared = 0;
  int numMismatched = 0;
  logic [15:0] expQ[$];
  logic [15:0] fetchVec;

  function automatic logic [15:0] mk(input logic pw, pwc, ps, iod, mr, mw, irw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, input logic [2:0] op);
    return {pw, pwc, ps, iod, mr, mw, irw, rw, rd, m2r, asa, asb, op};
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic stepCheck(input string tag);
    logic [15:0] exp;
    @(negedge clk);
    exp = expQ.pop_front();
    checkVal(tag, outVec, exp);
    checkVal({tag, "_excl"}, {14'd0, bus.memRead & bus.memWrite, bus.pcWrite & bus.pcWriteCond}, 16'd0);
  endtask

  // Expected per-cycle outputs, from FETCH through the last state of the instruction.
  task automatic pushInstr(input logic [3:0] opc, input logic z, input logic n, input logic m);
    expQ.push_back(fetchVec);
    expQ.push_back(16'd0);
    case (opc)
      4'b0000: begin
        expQ.push_back(mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,3'b000));
        expQ.push_back(mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,3'b000));
      end
      4'b0001: expQ.push_back(mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,3'b000));
      4'b0010: expQ.push_back(mk(1,0,1,0,0,0,0,0,0,0,0,2'b00,3'b000));
      4'b0100: expQ.push_back(mk(0,1,1,0,0,0,0,0,0,0,1,2'b00,3'b001));
      4'b1000: begin
        expQ.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b100));
        expQ.push_back(mk(0,0,0,0,0,0,0,~n,m,0,0,2'b00,3'b100));
      end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        expQ.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,{1'b0, opc[1:0]}));
        expQ.push_back(mk(0,0,0,0,0,0,0,1,0,0,1,2'b10,{1'b0, opc[1:0]}));
      end
      default: ;
    endcase
    if (z) begin end  // zero does not change any controller output
  endtask

  task automatic runInstr(input logic [3:0] opc, input logic z, input logic n, input logic m);
    int len;
    len = expQ.size();
    pushInstr(opc, z, n, m);
    len = expQ.size() - len;
    bus.zero = z;
    bus.noOp = n;
    bus.moveTo = m;
    for (int i = 0; i < len; i++) begin
      stepCheck($sformatf("op%b_z%0d_n%0d_m%0d_c%0d", opc, z, n, m, i));
      if (i == 0) begin
        bus.opcode = 4'($urandom);
        #1 bus.opcode = opc;
      end
    end
    $display("instr opcode=%b zero=%b noOp=%b moveTo=%b cycles=%0d", opc, z, n, m, len);
  endtask

  initial begin
    fetchVec = mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,3'b000);
    rst = 1'b0;
    bus.opcode = 4'b0000;
    bus.zero = 1'b0;
    bus.noOp = 1'b0;
    bus.moveTo = 1'b0;

    repeat (2) @(posedge clk);
    expQ.push_back(fetchVec);
    stepCheck("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    $display("reset released");

    runInstr(4'b0000, 1'b0, 1'b0, 1'b0);
    runInstr(4'b0001, 1'b0, 1'b0, 1'b0);
    runInstr(4'b0010, 1'b0, 1'b0, 1'b0);
    runInstr(4'b0100, 1'b1, 1'b0, 1'b0);
    runInstr(4'b0100, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1000, 1'b0, 1'b1, 1'b0);
    runInstr(4'b1000, 1'b0, 1'b0, 1'b1);
    runInstr(4'b1000, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1100, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1101, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1110, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1111, 1'b0, 1'b0, 1'b0);
    runInstr(4'b0111, 1'b0, 1'b0, 1'b0);
    runInstr(4'b1011, 1'b1, 1'b1, 1'b1);

    // Reset asserted while a C-type instruction sits in C_EXE
    bus.noOp = 1'b0;
    bus.moveTo = 1'b0;
    expQ.push_back(fetchVec);
    expQ.push_back(16'd0);
    expQ.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,3'b100));
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("rstMid_c%0d", i));
      if (i == 0) bus.opcode = 4'b1000;
    end
    rst = 1'b0;
    #2 checkVal("rstMid_comb", outVec, fetchVec);
    expQ.push_back(fetchVec);
    stepCheck("rstMid_hold0");
    expQ.push_back(fetchVec);
    stepCheck("rstMid_hold1");
    @(posedge clk);
    #1 rst = 1'b1;
    $display("mid-instruction reset applied and released");
    runInstr(4'b0000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      runInstr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
